// File: rtl/mux_2.sv
// mux_2: parameterised 2:1 data selector with a registered shadow stage.
// The combinational output y is the primary result. y_q and s_q hold the
// values sampled at the last enabled edge. switch_cnt counts select changes
// between enabled samples and saturates at all-ones.
module mux_2 #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic             s,
    input  logic             en,
    output logic [W-1:0]     y,
    output logic [W-1:0]     y_q,
    output logic             s_q,
    output logic [CNT_W-1:0] switch_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sel_changed;
    logic             cnt_at_max;

    // Steer the selected operand straight through, bit for bit; only s=1 picks d1.
    always_comb begin
        y = d0;
        if (s == 1'b1) begin
            y = d1;
        end
    end

    // A change is counted against the last enabled sample, not the previous cycle.
    always_comb begin
        sel_changed = (s != s_q);
        cnt_at_max  = (switch_cnt == CNT_MAX);
    end

    // Shadow registers: reset has priority over enable; en=0 holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q        <= '0;
            s_q        <= 1'b0;
            switch_cnt <= '0;
        end else if (en) begin
            y_q <= y;
            s_q <= s;
            if (sel_changed && !cnt_at_max) begin
                switch_cnt <= switch_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_2.sv
// Bench for mux_2: directed steps followed by a random phase, compared against
// an integer model. A second instance with a 2-bit counter exercises saturation.
module tb_mux_2;

    logic       clk = 1'b0;
    logic       rst;
    logic       s;
    logic       en;
    logic [7:0] d0;
    logic [7:0] d1;

    logic [7:0] y8, yq8, cnt8;
    logic       sq8;
    logic [7:0] y2, yq2;
    logic       sq2;
    logic [1:0] cnt2;

    int checks   = 0;
    int failures = 0;

    // model state
    int m_yq, m_sq, m_cnt8, m_cnt2;

    always #5 clk = ~clk;

    mux_2 #(.W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .d0(d0), .d1(d1), .s(s), .en(en),
        .y(y8), .y_q(yq8), .s_q(sq8), .switch_cnt(cnt8)
    );

    mux_2 #(.W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .d0(d0), .d1(d1), .s(s), .en(en),
        .y(y2), .y_q(yq2), .s_q(sq2), .switch_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sel_model(input logic sv, input logic [7:0] a, input logic [7:0] b);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (sv === 1'b1) r += int'(b[i]) << i;
            else             r += int'(a[i]) << i;
        end
        return r;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    task automatic check_y();
        #1;
        check("y_w8", {24'd0, y8}, sel_model(s, d0, d1));
        check("y_w8_cnt2", {24'd0, y2}, sel_model(s, d0, d1));
    endtask

    task automatic check_regs();
        check("y_q", {24'd0, yq8}, m_yq);
        check("s_q", {31'd0, sq8}, m_sq);
        check("switch_cnt8", {24'd0, cnt8}, m_cnt8);
        check("switch_cnt2", {30'd0, cnt2}, m_cnt2);
        check("y_q_cnt2", {24'd0, yq2}, m_yq);
    endtask

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst === 1'b1) begin
            m_yq = 0; m_sq = 0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (en === 1'b1) begin
            if (int'(s) != m_sq) begin
                m_cnt8 = sat_inc(m_cnt8, 255);
                m_cnt2 = sat_inc(m_cnt2, 3);
            end
            m_yq = sel_model(s, d0, d1);
            m_sq = int'(s);
        end
        #1;
        check_regs();
    endtask

    initial begin
        int sat_exp [6];
        sat_exp = '{1, 2, 3, 3, 3, 3};
        m_yq = 0; m_sq = 0; m_cnt8 = 0; m_cnt2 = 0;
        rst = 1'b0; en = 1'b0; s = 1'b0; d0 = 8'h00; d1 = 8'h00;
        #2;

        // select d0 without any clock edge requirement
        d0 = 8'hAA; d1 = 8'h11; s = 1'b0;
        #10;
        check("sel_d0", {24'd0, y8}, 32'hAA);

        d0 = 8'hFF; d1 = 8'h53; s = 1'b1;
        #10;
        check("sel_d1", {24'd0, y8}, 32'h53);

        // reset state
        rst = 1'b1; en = 1'b0;
        tick();
        check("rst_y_q", {24'd0, yq8}, 32'h0);
        check("rst_cnt", {24'd0, cnt8}, 32'h0);

        // first enabled edge with s=1 counts as a change
        rst = 1'b0; en = 1'b1; s = 1'b1; d1 = 8'h53;
        tick();
        check("reg_y_q", {24'd0, yq8}, 32'h53);
        check("reg_s_q", {31'd0, sq8}, 32'h1);
        check("reg_cnt", {24'd0, cnt8}, 32'h1);

        // enable low: y tracks, registers hold
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d0 = 8'($urandom); d1 = 8'($urandom); s = 1'($urandom);
            check_y();
            tick();
            check("hold_y_q", {24'd0, yq8}, 32'h53);
            check("hold_cnt", {24'd0, cnt8}, 32'h1);
        end

        // saturation of the 2-bit counter
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s = (i % 2 == 0) ? 1'b1 : 1'b0;
            d0 = 8'($urandom); d1 = 8'($urandom);
            tick();
            check("sat_cnt2", {30'd0, cnt2}, sat_exp[i]);
        end
        check("sat_cnt8", {24'd0, cnt8}, 32'd6);

        // reset wins over enable; y still follows inputs
        rst = 1'b1; en = 1'b1; s = 1'b1; d1 = 8'hFF;
        tick();
        check("rstpri_y_q", {24'd0, yq8}, 32'h0);
        check("rstpri_s_q", {31'd0, sq8}, 32'h0);
        check("rstpri_cnt", {24'd0, cnt8}, 32'h0);
        check("rstpri_y", {24'd0, y8}, 32'hFF);

        // random phase
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            d0  = 8'($urandom);
            d1  = 8'($urandom);
            s   = 1'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            check_y();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
